uart_tx_periph: RTL and testbench
=================================

Name: uart_tx_periph

Overview:
Memory-mapped UART transmitter peripheral for the 6502 system bus. It sits downstream of the CPU data-out bus, beside the existing receiver and LED port. CPU writes to the data register push bytes into a small FIFO. A TX state machine drains the FIFO as 8N1 frames on the serial line. Reads return status with the same one-cycle registered latency as the internal ROM/RAM path.

Parameters:
CLKS_PER_BIT, 234, cclk cycles per serial bit (27 MHz / 115200)
DEPTH, 8, FIFO depth in bytes; power of 2, minimum 2
CNT_W, 16, width of the bit-period counter

Ports:
cclk  input  1  system/CPU clock; all logic on posedge
reset  input  1  synchronous, active-high reset
cs  input  1  chip select from address decode (0x2010-0x201F)
we  input  1  CPU write enable, active high
addr  input  1  register select (CPU address bit 0)
wdata  input  8  CPU data out
rdata  output  8  registered read data
rvalid  output  1  registered "rdata drives bus" flag (cs & !we, delayed one cycle)
uart_tx  output  1  serial line, idle high, registered
irq_tx  output  1  TX-empty interrupt, active high (see Optional Feature)

Behaviour:
- Reset values: uart_tx=1, rdata=0x00, rvalid=0, irq_tx=0. On reset, FIFO is emptied, overflow flag cleared, FSM goes to IDLE, IRQ enable cleared.
- Reset mid-frame: uart_tx returns high on the next edge. The partial frame is abandoned.
- Register map:
  - addr0 write: push wdata.
  - addr0 read: FIFO entry count, zero-extended to 8 bits.
  - addr1 read: status {4'b0, overflow, fifo_empty, fifo_full, busy}.
  - busy = FSM not IDLE.
- Read timing: when cs & !we at edge N, rdata and rvalid are valid after edge N. rvalid=0 on any other cycle. rdata holds its last value when not read.
- Reading status clears overflow at the same edge; the returned value shows the pre-clear state.
- Push when full: byte dropped, FIFO unchanged, overflow set (sticky).
- Push and pop in the same cycle: both occur, and the count is unchanged. Exception: a push into a full FIFO on a pop cycle is accepted.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into shift reg, drive uart_tx=0, clear counter, go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then drive bit0 and go to DATA with bit_idx=0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit7's period, drive 1 and go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: a new start bit begins the cycle after STOP completes. The gap is 1 cycle of idle high.
  - Latency: a write at edge N to an empty FIFO with FSM in IDLE gives uart_tx=0 after edge N+1.
- Counter compares against CLKS_PER_BIT-1. It wraps to 0 at each bit boundary and never overflows CNT_W.
- FIFO pointers are log2(DEPTH)+1 bits wide; full/empty come from the MSB compare. Count range is 0..DEPTH.

Optional Feature:
UART_TX_IRQ_EN
- Defined:
  - An addr1 write sets irq_en = wdata[0].
  - irq_tx = irq_en & fifo_empty & !busy, registered, so it asserts one cycle after the last STOP completes.
  - Status bit4 reads irq_en.
- Undefined:
  - irq_tx is tied 0.
  - addr1 writes are ignored.
  - Status bit4 reads 0.

Decomposition:
- Package uart_pkg holds:
  - REG_DATA=1'b0 and REG_STAT=1'b1
  - the status bit positions (BUSY=0, FULL=1, EMPTY=2, OVF=3, IEN=4)
  - the 2-bit TX state encoding IDLE/START/DATA/STOP, shared with the receiver for consistency
- One sub-module, sync_fifo: parameterised DEPTH×8. It has push/pop/full/empty/count ports and the same synchronous reset.

Test Plan:
- CLKS_PER_BIT=4; reset; write 0x55 to addr0 → uart_tx low 1 cycle after the write edge. Line samples every 4 cycles read 0,1,0,1,0,1,0,1,0,1. The line goes idle at cycle 41.
- Write 0xA3 then 0x0F back-to-back → two frames with exactly 1 idle-high cycle between them; decoded bytes are 0xA3, 0x0F; status busy=1 throughout and 0 after.
- With the line held busy, write 9 bytes (DEPTH=8) → 1 pops immediately, so 8 are stored and none dropped. A 10th write → overflow=1. Status read returns 0x0A|…; a second read shows overflow=0.
- Read addr0 after 3 queued writes while FSM busy → rdata=0x02 or 0x03 per pop timing. Check the exact value against the model; rvalid high for exactly 1 cycle.
- Assert reset during DATA bit 3 → uart_tx=1 next cycle, count=0, no further start bit.
- With UART_TX_IRQ_EN: write 0x01 to addr1, send 0x42 → irq_tx rises 1 cycle after the STOP bit ends. Writing 0x00 to addr1 drops irq_tx next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, status bit positions and TX state encoding
// Imported by uart_tx_periph; the state encoding matches the receiver.
package uart_pkg;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_IEN   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous DEPTH x W byte FIFO with first-word fall-through head
// Ports: cclk, reset (sync, active-high), push/wdata, pop/rdata (head),
//        full, empty, count (0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     cclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge cclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge cclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with byte FIFO
// Ports: cclk, reset (sync, active-high), cs/we/addr/wdata (CPU bus),
//        rdata/rvalid (registered read path), uart_tx (serial out, idle high),
//        irq_tx (TX-empty interrupt).
// Optional macro UART_TX_IRQ_EN: addr1 write sets irq_en, status bit4 = irq_en,
// irq_tx = registered irq_en & fifo_empty & !busy. Undefined: irq_tx tied 0.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 16
) (
    input  logic       cclk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       uart_tx,
    output logic       irq_tx
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic          push;
    logic          pop;
    logic          stat_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          busy;
    logic          ien;
    logic [7:0]    status;

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             tx_reg, tx_n;
    logic             bit_done;

    assign push    = cs & we & (addr == REG_DATA);
    assign stat_rd = cs & ~we & (addr == REG_STAT);
    assign busy    = (state != IDLE);

    sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .cclk  (cclk),
        .reset (reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Overflow only when the byte is really dropped (full with no pop this cycle).
    always_ff @(posedge cclk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push & fifo_full & ~pop) begin
            overflow <= 1'b1;
        end else if (stat_rd) begin
            overflow <= 1'b0;
        end
    end

    assign bit_done = (cnt == BIT_LAST);

    always_ff @(posedge cclk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_reg  <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx_reg  <= tx_n;
        end
    end

    // The shift register moves right each data bit, so shreg[0] is the bit
    // currently on the line and shreg[1] is the next one.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = tx_reg;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_head;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_n     = '0;
                    tx_n      = shreg[0];
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign uart_tx = tx_reg;

`ifdef UART_TX_IRQ_EN
    logic irq_en;
    logic irq_q;

    always_ff @(posedge cclk) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (cs & we & (addr == REG_STAT)) irq_en <= wdata[0];
            irq_q <= irq_en & fifo_empty & ~busy;
        end
    end

    assign ien    = irq_en;
    assign irq_tx = irq_q;
`else
    assign ien    = 1'b0;
    assign irq_tx = 1'b0;
`endif

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = busy;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = overflow;
        status[ST_IEN]   = ien;
    end

    always_ff @(posedge cclk) begin
        if (reset) begin
            rdata  <= 8'h00;
            rvalid <= 1'b0;
        end else begin
            rvalid <= cs & ~we;
            if (cs & ~we) begin
                rdata <= (addr == REG_STAT) ? status : 8'(fifo_count);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - scoreboard bench for uart_tx_periph with a transaction-level model
module tb_uart_tx_periph;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       cclk = 1'b0;
    logic       reset;
    logic       cs;
    logic       we;
    logic       addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic       uart_tx;
    logic       irq_tx;

    int checks = 0;
    int errors = 0;

    always #5 cclk = ~cclk;

    uart_tx_periph #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .cclk    (cclk),
        .reset   (reset),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .uart_tx (uart_tx),
        .irq_tx  (irq_tx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle time %0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, transmitter as "busy until edge idle_from".
    int         cyc = 0;
    logic [7:0] mq[$];
    logic [7:0] txq[$];
    logic [7:0] rdq[$];
    int         idle_from = 0;
    int         frame_p = -100000;
    logic [7:0] frame_byte = 8'h00;
    logic       ovf_m = 1'b0;
    logic       ien_m = 1'b0;
    logic       exp_line = 1'b1;
    logic       exp_rvalid = 1'b0;
    logic       exp_irq = 1'b0;

    always @(posedge cclk) begin
        int   pre_count;
        int   o;
        bit   pre_busy;
        bit   pre_empty;
        bit   pre_full;
        cyc++;
        if (reset) begin
            mq.delete();
            txq.delete();
            rdq.delete();
            ovf_m      = 1'b0;
            ien_m      = 1'b0;
            idle_from  = 0;
            frame_p    = -100000;
            exp_rvalid = 1'b0;
            exp_irq    = 1'b0;
            exp_line   = 1'b1;
        end else begin
            pre_count = mq.size();
            pre_busy  = (cyc < idle_from);
            pre_empty = (pre_count == 0);
            pre_full  = (pre_count == DEPTH);
`ifdef UART_TX_IRQ_EN
            exp_irq = ien_m & pre_empty & !pre_busy;
`else
            exp_irq = 1'b0;
`endif
            exp_rvalid = cs & !we;
            if (cs && !we) begin
                if (addr) begin
                    rdq.push_back({3'b000, ien_m, ovf_m, pre_empty, pre_full, pre_busy});
                    ovf_m = 1'b0;
                end else begin
                    rdq.push_back(8'(pre_count));
                end
            end
            if (!pre_busy && !pre_empty) begin
                frame_byte = mq.pop_front();
                txq.push_back(frame_byte);
                frame_p   = cyc;
                idle_from = cyc + FRAME + 1;
            end
            if (cs && we && !addr) begin
                if (mq.size() < DEPTH) mq.push_back(wdata);
                else ovf_m = 1'b1;
            end
`ifdef UART_TX_IRQ_EN
            if (cs && we && addr) ien_m = wdata[0];
`endif
            o = cyc - frame_p;
            if (o >= 0 && o < FRAME) begin
                if (o < CPB) exp_line = 1'b0;
                else if (o >= 9 * CPB) exp_line = 1'b1;
                else exp_line = frame_byte[o / CPB - 1];
            end else begin
                exp_line = 1'b1;
            end
        end
    end

    // Monitor: per-cycle line/flag checks, read-data scoreboard, serial byte decoder.
    bit         dec_active = 1'b0;
    int         dec_s = 0;
    logic [7:0] dec_b = 8'h00;

    always @(negedge cclk) begin
        int t;
        if (cyc > 0) begin
            chk("uart_tx_line", uart_tx, exp_line);
            chk("rvalid", rvalid, exp_rvalid);
            chk("irq_tx", irq_tx, exp_irq);
            if (rvalid) begin
                if (rdq.size() > 0) begin
                    chk("rdata", rdata, rdq.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL rdata_unexpected: got %0h, expected no read", rdata);
                end
            end
            if (reset) begin
                dec_active = 1'b0;
            end else if (!dec_active) begin
                if (uart_tx == 1'b0) begin
                    dec_active = 1'b1;
                    dec_s      = cyc;
                    dec_b      = 8'h00;
                end
            end else begin
                t = cyc - dec_s;
                if ((t % CPB) == CPB / 2 && t / CPB >= 1 && t / CPB <= 8) begin
                    dec_b[t / CPB - 1] = uart_tx;
                end
                if (t == 9 * CPB + CPB / 2) begin
                    chk("stop_bit", uart_tx, 1'b1);
                    if (txq.size() > 0) begin
                        chk("tx_byte", dec_b, txq.pop_front());
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL tx_byte_unexpected: got %0h, expected no frame", dec_b);
                    end
                    dec_active = 1'b0;
                end
            end
        end
    end

    task automatic bus(input logic w, input logic a, input logic [7:0] d);
        @(negedge cclk);
        cs    = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle(input int n);
        @(negedge cclk);
        cs = 1'b0;
        we = 1'b0;
        repeat (n) @(negedge cclk);
    endtask

    initial begin
        int r;
        reset = 1'b1;
        cs    = 1'b0;
        we    = 1'b0;
        addr  = 1'b0;
        wdata = 8'h00;
        repeat (3) @(negedge cclk);
        chk("rdata_reset", rdata, 8'h00);
        chk("uart_tx_reset", uart_tx, 1'b1);
        reset = 1'b0;

        // Single frame
        bus(1'b1, 1'b0, 8'h55);
        idle(45);

        // Back-to-back frames with status polling
        bus(1'b1, 1'b0, 8'hA3);
        bus(1'b1, 1'b0, 8'h0F);
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, 1'b1, 8'h00);
            idle(10);
        end
        idle(20);
        bus(1'b0, 1'b1, 8'h00);

        // Fill to full, then overflow, status twice, count
        for (int i = 0; i < 10; i++) bus(1'b1, 1'b0, 8'($urandom));
        bus(1'b0, 1'b1, 8'h00);
        bus(1'b0, 1'b1, 8'h00);
        bus(1'b0, 1'b0, 8'h00);
        idle(400);

        // Count read with three queued writes
        for (int i = 0; i < 3; i++) bus(1'b1, 1'b0, 8'($urandom));
        bus(1'b0, 1'b0, 8'h00);
        idle(140);

        // Randomised traffic, including ignored/irq-enable addr1 writes
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) bus(1'b1, 1'b0, 8'($urandom));
            else if (r == 3) bus(1'b0, 1'b1, 8'h00);
            else if (r == 4) bus(1'b0, 1'b0, 8'h00);
            else if (r == 5) bus(1'b1, 1'b1, 8'($urandom));
            else idle($urandom_range(0, 12));
        end
        idle(450);

        // Reset during data bit 3 with bytes still queued
        for (int i = 0; i < 3; i++) bus(1'b1, 1'b0, 8'($urandom));
        idle(14);
        reset = 1'b1;
        @(negedge cclk);
        reset = 1'b0;
        bus(1'b0, 1'b0, 8'h00);
        idle(60);

`ifdef UART_TX_IRQ_EN
        bus(1'b1, 1'b1, 8'h01);
        bus(1'b1, 1'b0, 8'h42);
        idle(50);
        bus(1'b1, 1'b1, 8'h00);
        idle(5);
`endif

        chk("frames_drained", txq.size(), 0);
        chk("reads_drained", rdq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
